// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch stage with a prefetch FIFO and multiple outstanding instruction-RAM reads
module if_prefetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] PC_RESET_ADDR = '0,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic              id_pipe_valid,
  input  logic              id_pipe_ready,
  input  logic              id_pipe_flush,
  output logic [XLEN-1:0]   id_pipe_pc,
  output logic [XLEN-1:0]   id_pipe_instruction,
  input  logic              ex_branch,
  input  logic [XLEN-1:0]   ex_branch_pc,
  input  logic              wb_trap,
  input  logic [XLEN-1:0]   wb_trap_pc,
  output logic              iram_req,
  output logic              iram_write,
  output logic [XLEN/8-1:0] iram_wstrb,
  output logic [XLEN-1:0]   iram_addr,
  output logic [XLEN-1:0]   iram_wdata,
  input  logic              iram_ready,
  input  logic              iram_rvalid,
  input  logic [XLEN-1:0]   iram_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_resp_pc;
  logic [CW-1:0]     r_out;
  logic [CW-1:0]     r_disc;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [2*XLEN-1:0] r_mem [FIFO_DEPTH];

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_acc;
  logic            w_drop;
  logic            w_keep;
  logic            w_empty;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_load;
  logic [CW-1:0]   w_credit;
  logic [CW-1:0]   w_out_n;

  assign w_redirect = wb_trap | ex_branch;
  assign w_target   = (wb_trap ? wb_trap_pc : ex_branch_pc) & ~XLEN'(3);
  // Buffered plus in-flight non-discarded reads may never exceed the FIFO, so responses always have a slot
  assign w_credit   = r_cnt + r_out - r_disc;
  assign iram_req   = rst_b & ~w_redirect & (r_out < MAXO) & (w_credit < DEPTH);
  assign w_acc      = iram_req & iram_ready;
  assign w_drop     = iram_rvalid & (r_disc != '0);
  assign w_keep     = iram_rvalid & (r_disc == '0);
  assign w_empty    = r_cnt == '0;
  // A flushed cycle does not load the output, so a response arriving then is kept in the FIFO
  assign w_bypass   = w_keep & w_empty & id_pipe_ready & ~id_pipe_flush;
  assign w_push     = w_keep & ~w_bypass;
  assign w_load     = (~w_empty | w_keep) & ~id_pipe_flush & ~w_redirect;
  assign w_pop      = id_pipe_ready & ~w_empty & ~id_pipe_flush & ~w_redirect;
  assign w_out_n    = r_out + CW'(w_acc) - CW'(iram_rvalid);

  assign iram_write = 1'b0;
  assign iram_wstrb = '0;
  assign iram_wdata = '0;
  assign iram_addr  = r_fetch_pc;

  // Fetch/response pointers, in-flight bookkeeping and FIFO occupancy; a redirect restarts all of it
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_fetch_pc <= PC_RESET_ADDR;
      r_resp_pc  <= PC_RESET_ADDR;
      r_out      <= '0;
      r_disc     <= '0;
      r_cnt      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      r_fetch_pc <= w_redirect ? w_target : w_acc ? r_fetch_pc + XLEN'(4) : r_fetch_pc;
      r_resp_pc  <= w_redirect ? w_target : w_keep ? r_resp_pc + XLEN'(4) : r_resp_pc;
      r_out      <= w_out_n;
      r_disc     <= w_redirect ? w_out_n : r_disc - CW'(w_drop);
      r_cnt      <= w_redirect ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
      r_wp       <= w_redirect ? '0 : r_wp + PW'(w_push);
      r_rp       <= w_redirect ? '0 : r_rp + PW'(w_pop);
    end
  end

  // FIFO storage of {pc, instruction}
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {r_resp_pc, iram_rdata};
  end

  // ID pipeline register, loaded from the FIFO head or straight from the RAM when the FIFO is empty
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      id_pipe_valid       <= 1'b0;
      id_pipe_pc          <= '0;
      id_pipe_instruction <= '0;
    end else if (id_pipe_ready) begin
      id_pipe_valid                     <= w_load;
      {id_pipe_pc, id_pipe_instruction} <= w_empty ? {r_resp_pc, iram_rdata} : r_mem[r_rp];
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed tests of the prefetching fetch stage against an in-order RAM model
module tb_if_prefetch;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        id_pipe_valid;
  logic        id_pipe_ready = 1'b1;
  logic        id_pipe_flush = 1'b0;
  logic [31:0] id_pipe_pc;
  logic [31:0] id_pipe_instruction;
  logic        ex_branch = 1'b0;
  logic [31:0] ex_branch_pc = '0;
  logic        wb_trap = 1'b0;
  logic [31:0] wb_trap_pc = '0;
  logic        iram_req;
  logic        iram_write;
  logic [3:0]  iram_wstrb;
  logic [31:0] iram_addr;
  logic [31:0] iram_wdata;
  logic        iram_ready = 1'b0;
  logic        iram_rvalid = 1'b0;
  logic [31:0] iram_rdata = '0;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int rdy_pct = 100;
  int n_acc = 0;
  int max_out = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_ins[$];
  logic [31:0] exp_pc;

  if_prefetch #(
    .XLEN(32),
    .PC_RESET_ADDR(32'h100),
    .FIFO_DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .id_pipe_valid(id_pipe_valid),
    .id_pipe_ready(id_pipe_ready),
    .id_pipe_flush(id_pipe_flush),
    .id_pipe_pc(id_pipe_pc),
    .id_pipe_instruction(id_pipe_instruction),
    .ex_branch(ex_branch),
    .ex_branch_pc(ex_branch_pc),
    .wb_trap(wb_trap),
    .wb_trap_pc(wb_trap_pc),
    .iram_req(iram_req),
    .iram_write(iram_write),
    .iram_wstrb(iram_wstrb),
    .iram_addr(iram_addr),
    .iram_wdata(iram_wdata),
    .iram_ready(iram_ready),
    .iram_rvalid(iram_rvalid),
    .iram_rdata(iram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model (instruction word = ~address, in-order responses) and consumed-instruction monitor
  always @(negedge clk) begin
    ncyc++;
    if (!rst_b) begin
      q_addr.delete();
      q_due.delete();
    end
    if (rst_b && q_addr.size() > 0 && q_due[0] <= ncyc) begin
      iram_rvalid = 1'b1;
      iram_rdata = ~q_addr.pop_front();
      void'(q_due.pop_front());
    end else begin
      iram_rvalid = 1'b0;
      iram_rdata = '0;
    end
    iram_ready = $urandom_range(99) < rdy_pct;
    #2;
    if (iram_req && iram_ready) begin
      q_addr.push_back(iram_addr);
      q_due.push_back(ncyc + int'($urandom_range(lat_hi, lat_lo)));
      n_acc++;
    end
    if (q_addr.size() > max_out) max_out = q_addr.size();
    #1;
    if (id_pipe_valid && id_pipe_ready && !id_pipe_flush && !ex_branch && !wb_trap) begin
      obs_pc.push_back(id_pipe_pc);
      obs_ins.push_back(id_pipe_instruction);
    end
  end

  task automatic test_reset;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (id_pipe_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", id_pipe_valid); end
    checks++; if (id_pipe_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", id_pipe_pc); end
    checks++; if (id_pipe_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", id_pipe_instruction); end
    checks++; if (iram_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", iram_req); end
    checks++; if (iram_write !== 1'b0 || iram_wstrb !== 4'h0 || iram_wdata !== 32'h0) begin failures++; $display("FAIL write_tie got=%0h/%h/%h exp=0/0/0", iram_write, iram_wstrb, iram_wdata); end
  endtask

  task automatic test_sequential;
    logic [31:0] p, ins;
    int n = 0;
    exp_pc = 32'h100;
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    checks++; if (iram_req !== 1'b1 || iram_addr !== 32'h100) begin failures++; $display("FAIL first_req got req=%0h addr=%h exp req=1 addr=00000100", iram_req, iram_addr); end
    @(negedge clk);
    #1;
    checks++; if (id_pipe_valid !== 1'b0) begin failures++; $display("FAIL first_latency got valid=%0h exp=0", id_pipe_valid); end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (id_pipe_valid !== 1'b1 || id_pipe_pc !== 32'h100 + 32'(4 * i) || id_pipe_instruction !== ~(32'h100 + 32'(4 * i))) begin failures++; $display("FAIL seq_%0d got valid=%0h pc=%h ins=%h exp valid=1 pc=%h", i, id_pipe_valid, id_pipe_pc, id_pipe_instruction, 32'h100 + 32'(4 * i)); end
      @(negedge clk);
    end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL seq_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    checks++; if (n != 6) begin failures++; $display("FAIL seq_count got=%0d exp=6", n); end
  endtask

  task automatic test_backpressure;
    logic [31:0] p, ins;
    int n = 0;
    int a0;
    a0 = n_acc;
    id_pipe_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (iram_req !== 1'b0) begin failures++; $display("FAIL bp_req got=%0h exp=0", iram_req); end
    checks++; if (n_acc - a0 != 3) begin failures++; $display("FAIL bp_accepts got=%0d exp=3", n_acc - a0); end
    checks++; if (id_pipe_valid !== 1'b1 || id_pipe_pc !== exp_pc) begin failures++; $display("FAIL bp_hold got valid=%0h pc=%h exp valid=1 pc=%h", id_pipe_valid, id_pipe_pc, exp_pc); end
    id_pipe_ready = 1'b1;
    repeat (12) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL bp_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    checks++; if (n < 10) begin failures++; $display("FAIL bp_count got=%0d exp>=10", n); end
  endtask

  task automatic test_branch;
    logic [31:0] p, ins;
    int n = 0;
    int w = 0;
    lat_lo = 2;
    lat_hi = 2;
    repeat (6) @(negedge clk);
    forever begin
      #1;
      if (q_addr.size() + int'(iram_rvalid) == 2 || w == 10) break;
      w++;
      @(negedge clk);
    end
    checks++; if (w == 10) begin failures++; $display("FAIL br_setup got outstanding=%0d exp=2", q_addr.size() + int'(iram_rvalid)); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front();
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL br_pre_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    ex_branch = 1'b1;
    ex_branch_pc = 32'h201;
    exp_pc = 32'h200;
    #1;
    checks++; if (iram_req !== 1'b0) begin failures++; $display("FAIL br_req got=%0h exp=0", iram_req); end
    @(negedge clk);
    ex_branch = 1'b0;
    #1;
    checks++; if (id_pipe_valid !== 1'b0) begin failures++; $display("FAIL br_kill got valid=%0h exp=0", id_pipe_valid); end
    checks++; if (iram_addr !== 32'h200) begin failures++; $display("FAIL br_addr got=%h exp=00000200", iram_addr); end
    repeat (12) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL br_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    checks++; if (n < 4) begin failures++; $display("FAIL br_count got=%0d exp>=4", n); end
  endtask

  task automatic test_trap_branch;
    logic [31:0] p, ins;
    int n = 0;
    lat_lo = 1;
    lat_hi = 1;
    repeat (6) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front();
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL tb_pre_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    wb_trap = 1'b1;
    wb_trap_pc = 32'h80;
    ex_branch = 1'b1;
    ex_branch_pc = 32'h300;
    exp_pc = 32'h80;
    @(negedge clk);
    wb_trap = 1'b0;
    ex_branch = 1'b0;
    #1;
    checks++; if (iram_addr !== 32'h80 || id_pipe_valid !== 1'b0) begin failures++; $display("FAIL trap_addr got addr=%h valid=%0h exp addr=00000080 valid=0", iram_addr, id_pipe_valid); end
    @(negedge clk);
    #1;
    checks++; if (id_pipe_valid !== 1'b0) begin failures++; $display("FAIL trap_r2 got valid=%0h exp=0", id_pipe_valid); end
    @(negedge clk);
    #1;
    checks++; if (id_pipe_valid !== 1'b1 || id_pipe_pc !== 32'h80 || id_pipe_instruction !== ~32'h80) begin failures++; $display("FAIL trap_r3 got valid=%0h pc=%h ins=%h exp valid=1 pc=00000080", id_pipe_valid, id_pipe_pc, id_pipe_instruction); end
    repeat (8) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL trap_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    checks++; if (n < 6) begin failures++; $display("FAIL trap_count got=%0d exp>=6", n); end
  endtask

  task automatic test_flush;
    logic [31:0] p, ins;
    int n = 0;
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front();
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL fl_pre_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    id_pipe_flush = 1'b1;
    exp_pc = exp_pc + 32'd4;
    @(negedge clk);
    id_pipe_flush = 1'b0;
    #1;
    checks++; if (id_pipe_valid !== 1'b0) begin failures++; $display("FAIL flush_kill got valid=%0h exp=0", id_pipe_valid); end
    @(negedge clk);
    #1;
    checks++; if (id_pipe_valid !== 1'b1 || id_pipe_pc !== exp_pc) begin failures++; $display("FAIL flush_next got valid=%0h pc=%h exp valid=1 pc=%h", id_pipe_valid, id_pipe_pc, exp_pc); end
    repeat (6) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL flush_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    checks++; if (n < 4) begin failures++; $display("FAIL flush_count got=%0d exp>=4", n); end
  endtask

  task automatic test_random;
    logic [31:0] p, ins;
    int n = 0;
    lat_lo = 1;
    lat_hi = 4;
    rdy_pct = 70;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ex_branch = 1'b0;
      wb_trap = 1'b0;
      id_pipe_ready = $urandom_range(3) != 0;
      if ($urandom_range(24) == 0) begin
        while (obs_pc.size() > 0) begin
          p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
          checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL rnd_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
          exp_pc = p + 32'd4;
        end
        id_pipe_ready = 1'b1;
        ex_branch = $urandom_range(1) != 0;
        wb_trap = !ex_branch || $urandom_range(1) != 0;
        ex_branch_pc = $urandom & 32'h3ff;
        wb_trap_pc = $urandom & 32'h3ff;
        exp_pc = (wb_trap ? wb_trap_pc : ex_branch_pc) & ~32'h3;
      end
    end
    @(negedge clk);
    ex_branch = 1'b0;
    wb_trap = 1'b0;
    id_pipe_ready = 1'b1;
    rdy_pct = 100;
    lat_hi = 1;
    repeat (20) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL rnd_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    checks++; if (n < 40) begin failures++; $display("FAIL rnd_count got=%0d exp>=40", n); end
    checks++; if (max_out > 2) begin failures++; $display("FAIL max_outstanding got=%0d exp<=2", max_out); end
  endtask

  task automatic test_async_reset;
    logic [31:0] p, ins;
    int n = 0;
    int w = 0;
    lat_lo = 2;
    lat_hi = 2;
    repeat (6) @(negedge clk);
    forever begin
      #1;
      if (q_addr.size() + int'(iram_rvalid) == 2 || w == 10) break;
      w++;
      @(negedge clk);
    end
    checks++; if (w == 10) begin failures++; $display("FAIL ar_setup got outstanding=%0d exp=2", q_addr.size() + int'(iram_rvalid)); end
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front();
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL ar_pre_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    rst_b = 1'b0;
    #1;
    checks++; if (id_pipe_valid !== 1'b0 || iram_req !== 1'b0) begin failures++; $display("FAIL ar_immediate got valid=%0h req=%0h exp 0/0", id_pipe_valid, iram_req); end
    checks++; if (id_pipe_pc !== 32'h0 || id_pipe_instruction !== 32'h0) begin failures++; $display("FAIL ar_regs got pc=%h ins=%h exp 0/0", id_pipe_pc, id_pipe_instruction); end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    exp_pc = 32'h100;
    #1;
    checks++; if (iram_req !== 1'b1 || iram_addr !== 32'h100) begin failures++; $display("FAIL ar_restart got req=%0h addr=%h exp req=1 addr=00000100", iram_req, iram_addr); end
    repeat (10) @(negedge clk);
    while (obs_pc.size() > 0) begin
      p = obs_pc.pop_front(); ins = obs_ins.pop_front(); n++;
      checks++; if (p !== exp_pc || ins !== ~exp_pc) begin failures++; $display("FAIL ar_stream got pc=%h ins=%h exp pc=%h ins=%h", p, ins, exp_pc, ~exp_pc); end
      exp_pc = p + 32'd4;
    end
    checks++; if (n < 3) begin failures++; $display("FAIL ar_count got=%0d exp>=3", n); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_sequential;
    test_backpressure;
    test_branch;
    test_trap_branch;
    test_flush;
    test_random;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a prefetch buffer and multiple outstanding instruction-RAM reads. It sits between the instruction RAM and the ID stage and supplies in-order {pc, instruction} pairs through the ID pipeline register. Branch and trap redirects from EX/WB discard in-flight and buffered fetches without stalling the RAM port. It supersedes the single-outstanding IF stage, which used a backup register.

## Interface
Parameters:
- XLEN, 32, data/address width.
- PC_RESET_ADDR, XLEN'h0, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch buffer entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned RAM reads; 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset. One clock domain; reset is asynchronous and active-low.
- id_pipe_valid  out  1  ID pipeline register valid.
- id_pipe_ready  in  1  ID accepts/advances; the output register loads only when this is high.
- id_pipe_flush  in  1  kill the ID pipeline register contents.
- id_pipe_pc  out  XLEN  pc of the presented instruction.
- id_pipe_instruction  out  XLEN  presented instruction.
- ex_branch  in  1  jump or taken branch (1-cycle pulse).
- ex_branch_pc  in  XLEN  branch target.
- wb_trap  in  1  trap redirect (1-cycle pulse); has priority over ex_branch.
- wb_trap_pc  in  XLEN  trap target.
- iram_req  out  1  read request.
- iram_write  out  1  tied 0.
- iram_wstrb  out  XLEN/8  tied 0.
- iram_addr  out  XLEN  read address = fetch_pc.
- iram_wdata  out  XLEN  tied 0.
- iram_ready  in  1  request accepted when iram_req & iram_ready.
- iram_rvalid  in  1  read data valid. Responses are in order and not back-pressurable; each arrives ≥1 cycle after acceptance.
- iram_rdata  in  XLEN  read data.

## Operation
- **State:**
  - fetch_pc: next address to request.
  - resp_pc: pc of the next non-discarded response.
  - outstanding: count, 0..MAX_OUTSTANDING.
  - discard: count, 0..MAX_OUTSTANDING.
  - FIFO: {pc, instr}, FIFO_DEPTH entries, with count.
- **Issue:**
  - iram_req = rst_b & ~redirect & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding − discard < FIFO_DEPTH).
  - This credit rule guarantees the FIFO never overflows.
  - On acceptance: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding++.
- **Response:**
  - iram_rvalid with discard>0: drop the response; discard−− and outstanding−−.
  - Otherwise: outstanding−−; push {resp_pc, iram_rdata} and resp_pc += 4.
  - Bypass: if the FIFO is empty and id_pipe_ready is high, the response loads the output register directly.
- **Output register**, loaded when id_pipe_ready:
  - id_pipe_valid <= (fifo non-empty | bypass response) & ~id_pipe_flush & ~redirect.
  - id_pipe_pc and id_pipe_instruction load from the FIFO head, or from the bypass response.
  - A FIFO pop occurs only when id_pipe_valid is loaded high.
  - When id_pipe_ready is low, all output register fields hold.
- **Redirect:**
  - redirect = wb_trap | ex_branch; target = wb_trap ? wb_trap_pc : ex_branch_pc, with bits [1:0] forced to 0.
  - In the redirect cycle: fetch_pc <= target; resp_pc <= target; FIFO cleared.
  - discard <= outstanding after this cycle's acceptance and response (all in-flight reads). No request is issued in the redirect cycle.
- **id_pipe_flush alone:** clears id_pipe_valid on the next id_pipe_ready edge; the FIFO is unaffected.
- **Reset (async):**
  - id_pipe_valid=0, id_pipe_pc=0, id_pipe_instruction=0.
  - fetch_pc = resp_pc = PC_RESET_ADDR.
  - outstanding = discard = fifo_count = 0.
  - iram_req=0 while rst_b=0.

## Timing
- Request accepted in cycle T, rvalid in T+1, FIFO empty and id_pipe_ready=1 → id_pipe_valid high in T+2.
- If the response is buffered instead, it is presented ≥1 cycle after the FIFO head pops.
- First request after reset release: the cycle after rst_b rises, addr=PC_RESET_ADDR.
- Redirect in cycle R: the first request to the target is in R+1. With immediate ready and 1-cycle response, the target instruction is valid in R+3.
- **Boundaries:**
  - Response in the same cycle as a redirect: the response is counted and dropped.
  - Redirect while discard>0: discard is recomputed from the new outstanding count.
  - wb_trap together with ex_branch: the trap target wins.
  - FIFO full with id_pipe_ready low: iram_req stays 0, and no in-flight response is lost.
  - Full throughput: 1 instruction/cycle sustained when iram_ready=1, id_pipe_ready=1 and MAX_OUTSTANDING≥2.

## Test plan
- **Reset and sequential fetch:** PC_RESET_ADDR=0x100, RAM always ready, 1-cycle latency → iram_addr 0x100, 0x104, …; id_pipe_pc 0x100, 0x104, … back-to-back, first valid 2 cycles after the first request.
- **ID back-pressure:** hold id_pipe_ready=0 for 10 cycles with FIFO_DEPTH=4 → at most 4 accepted-but-unconsumed reads; iram_req drops; after release, pcs continue with no gap or duplicate.
- **Branch with 2 in flight:** ex_branch to 0x200 while outstanding=2 → both old responses dropped; the next presented pc is 0x200; the prior id_pipe_valid is cleared.
- **Trap and branch together:** wb_trap_pc=0x80 and ex_branch_pc=0x300 in the same cycle → fetch restarts at 0x80.
- **Random iram_ready/rvalid latency (1–4 cycles) with random redirects:** the ID stream equals the golden sequential-pc model; the outstanding count is never >MAX_OUTSTANDING; the FIFO never overflows.
- **Async reset mid-burst:** rst_b low with outstanding=2 → id_pipe_valid=0 immediately and iram_req=0; after release, fetch restarts at PC_RESET_ADDR.
